// File: rtl/hv_owt_tx_arb.sv
// ----------------------------------------------------------------------------
// hv_owt_tx_arb
// Shares the single one-wire TX frame controller among REQ_NUM requesters.
// Pending requests are arbitrated in IDLE. The winner's payload is latched,
// one wr/rd command pulse is issued together with the requester's ack, and
// then the arbiter stays busy for the frame time plus the inter-frame gap.
// Busy is timed locally because the TX controller has no busy/done output.
//
// Optional feature (compile-time macro):
//   HV_OWT_TX_ARB_PRIO_EN - requester 0 gets strict priority. The remaining
//                           requesters share round-robin among themselves.
//   When undefined, every requester, including 0, is plain round-robin.
// ----------------------------------------------------------------------------
module hv_owt_tx_arb #(
    parameter int REQ_NUM   = 3,
    parameter int REG_AW    = 7,
    parameter int DATA_W    = 16,
    parameter int FRAME_CYC = 400,
    parameter int IFG_CYC   = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [REQ_NUM-1:0]          i_req,
    input  logic [REQ_NUM-1:0]          i_req_wr,
    input  logic [REQ_NUM*REG_AW-1:0]   i_req_addr,
    input  logic [REQ_NUM*DATA_W-1:0]   i_req_data,
    output logic [REQ_NUM-1:0]          o_req_ack,
    output logic                        o_owt_tx_wr_cmd_vld,
    output logic                        o_owt_tx_rd_cmd_vld,
    output logic [REG_AW-1:0]           o_owt_tx_addr,
    output logic [DATA_W-1:0]           o_owt_tx_data,
    output logic [$clog2(REQ_NUM)-1:0]  o_grant_id,
    output logic                        o_busy
);

    localparam int ID_W    = $clog2(REQ_NUM);
    localparam int CNT_MAX = (FRAME_CYC > IFG_CYC) ? FRAME_CYC : IFG_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Counter reload values: the counter reaches 0 in the last cycle of a phase.
    localparam logic [CNT_W-1:0] FRAME_LOAD = CNT_W'(FRAME_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = (IFG_CYC > 0) ? CNT_W'(IFG_CYC - 1) : '0;
    localparam logic [ID_W-1:0]  LAST_ID    = ID_W'(REQ_NUM - 1);
    localparam logic [ID_W:0]    REQ_NUM_W  = (ID_W + 1)'(REQ_NUM);

    // FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_FRAME = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    rr_ptr_nxt;

    logic               arb_found;
    logic [ID_W-1:0]    arb_id;
    logic [ID_W:0]      arb_sum;
    logic [ID_W-1:0]    arb_idx;
    logic               grant;

    logic               sel_wr;
    logic [REG_AW-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;
    logic [REQ_NUM-1:0] ack_nxt;

    // Arbitration: scan upward from rr_ptr with wrap and take the first pending request.
    always_comb begin
        arb_found = 1'b0;
        arb_id    = '0;
        arb_sum   = '0;
        arb_idx   = '0;
`ifdef HV_OWT_TX_ARB_PRIO_EN
        if (i_req[0]) begin
            arb_found = 1'b1;
        end
`endif
        for (int i = 0; i < REQ_NUM; i++) begin
            arb_sum = {1'b0, rr_ptr} + (ID_W + 1)'(i);
            if (arb_sum >= REQ_NUM_W) begin
                arb_sum = arb_sum - REQ_NUM_W;
            end
            arb_idx = arb_sum[ID_W-1:0];
            if (!arb_found && i_req[arb_idx]) begin
                arb_found = 1'b1;
                arb_id    = arb_idx;
            end
        end
    end

    // A grant can only be taken while IDLE; requests during a frame simply wait.
    assign grant = (state == ST_IDLE) && arb_found;

    // Payload mux for the winning requester, plus its one-hot ack pattern.
    always_comb begin
        sel_wr   = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        ack_nxt  = '0;
        for (int k = 0; k < REQ_NUM; k++) begin
            if (arb_id == ID_W'(k)) begin
                sel_wr     = i_req_wr[k];
                sel_addr   = i_req_addr[k*REG_AW +: REG_AW];
                sel_data   = i_req_data[k*DATA_W +: DATA_W];
                ack_nxt[k] = 1'b1;
            end
        end
    end

    // Round-robin pointer moves past the winner; with priority enabled a grant to 0 leaves it alone.
    always_comb begin
        rr_ptr_nxt = rr_ptr;
        if (grant) begin
`ifdef HV_OWT_TX_ARB_PRIO_EN
            if (arb_id != '0)
`endif
            rr_ptr_nxt = (arb_id == LAST_ID) ? '0 : arb_id + ID_W'(1);
        end
    end

    // Next-state logic: ISSUE is one cycle, FRAME and GAP end when the counter hits 0.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (arb_found) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_nxt = ST_FRAME;
            end
            ST_FRAME: begin
                if (cnt == '0) begin
                    state_nxt = (IFG_CYC > 0) ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                if (cnt == '0) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register and round-robin pointer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= ST_IDLE;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_ptr_nxt;
        end
    end

    // Phase counter: loaded on entry to FRAME and GAP, counts down to 0 and stops there.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else begin
            case (state)
                ST_ISSUE: begin
                    cnt <= FRAME_LOAD;
                end
                ST_FRAME: begin
                    if (cnt == '0) begin
                        cnt <= GAP_LOAD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    // Registered outputs: pulses and ack for the ISSUE cycle, payload held until the next grant.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_req_ack           <= '0;
            o_owt_tx_wr_cmd_vld <= 1'b0;
            o_owt_tx_rd_cmd_vld <= 1'b0;
            o_owt_tx_addr       <= '0;
            o_owt_tx_data       <= '0;
            o_grant_id          <= '0;
            o_busy              <= 1'b0;
        end else begin
            o_req_ack           <= grant ? ack_nxt : '0;
            o_owt_tx_wr_cmd_vld <= grant && sel_wr;
            o_owt_tx_rd_cmd_vld <= grant && !sel_wr;
            o_busy              <= (state_nxt != ST_IDLE);
            if (grant) begin
                o_owt_tx_addr <= sel_addr;
                o_owt_tx_data <= sel_data;
                o_grant_id    <= arb_id;
            end
        end
    end

endmodule
